hack_mem_port: RTL and testbench



---
 rtl/hack_pkg.sv | 26 ++
 rtl/hack_addr_decode.sv | 37 +++
 rtl/hack_mem_port.sv | 187 ++++++++++++++++++
 tb/tb_hack_mem_port.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and default memory-map constants for the Hack data-memory path.
// Combinational definitions only; no latency.
// No flow control of its own; users add their own handshakes.
package hack_pkg;

  // Where a data-memory address lands in the Hack memory map.
  typedef enum logic [1:0] {
    RAM    = 2'd0,
    SCREEN = 2'd1,
    KBD    = 2'd2,
    NONE   = 2'd3
  } region_e;

  // Memory port sequencing.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_e;

  // Default map: RAM 0x0000-0x3FFF, screen 0x4000-0x5FFF, keyboard at 0x6000.
  localparam logic [15:0] HACK_RAM_TOP  = 16'h3FFF;
  localparam logic [15:0] HACK_SCR_TOP  = 16'h5FFF;
  localparam logic [15:0] HACK_KBD_ADDR = 16'h6000;

endpackage

// File: rtl/hack_addr_decode.sv
// Maps a 15-bit Hack data address to a region and a 14-bit word offset in that region.
// Purely combinational, zero latency.
// No backpressure; the result follows the address. Shared with the screen/VGA path.
module hack_addr_decode
  import hack_pkg::*;
#(
  parameter logic [15:0] RAM_TOP  = HACK_RAM_TOP,
  parameter logic [15:0] SCR_TOP  = HACK_SCR_TOP,
  parameter logic [15:0] KBD_ADDR = HACK_KBD_ADDR
) (
  input  logic [14:0] addr,
  output region_e     region,
  output logic [13:0] offset
);

  // First screen word; only the low 14 bits matter for the in-region offset.
  localparam logic [13:0] SCR_BASE = 14'(RAM_TOP + 16'd1);

  logic [15:0] addr16;
  assign addr16 = {1'b0, addr};

  // Ordered compare against the region tops; everything past the keyboard is unmapped.
  always_comb begin
    region = NONE;
    offset = '0;
    if (addr16 <= RAM_TOP) begin
      region = RAM;
      offset = addr[13:0];
    end else if (addr16 <= SCR_TOP) begin
      region = SCREEN;
      offset = addr[13:0] - SCR_BASE;
    end else if (addr16 == KBD_ADDR) begin
      region = KBD;
    end
  end

endmodule

// File: rtl/hack_mem_port.sv
// Hack CPU data-memory port: runs addressM/writeM/outM against RAM/screen over a req/ack bus, serves the keyboard locally.
// Latency request edge to cpu_rvalid: 1 cycle for keyboard/unmapped, bus wait + 2 for RAM/screen.
// Holds the CPU with stall until the access is registered; HACK_MEM_TIMEOUT_EN adds an ack watchdog with sticky err.
module hack_mem_port
  import hack_pkg::*;
#(
  parameter logic [15:0] RAM_TOP  = HACK_RAM_TOP,
  parameter logic [15:0] SCR_TOP  = HACK_SCR_TOP,
  parameter logic [15:0] KBD_ADDR = HACK_KBD_ADDR,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [14:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] kbd_code,
  output logic        err
);

  region_e     dec_region;
  logic [13:0] dec_offset;

  hack_addr_decode #(
    .RAM_TOP  (RAM_TOP),
    .SCR_TOP  (SCR_TOP),
    .KBD_ADDR (KBD_ADDR)
  ) u_decode (
    .addr   (cpu_addr),
    .region (dec_region),
    .offset (dec_offset)
  );

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_sel_q, mem_sel_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

`ifdef HACK_MEM_TIMEOUT_EN
  // Counter is zero outside MEM_WAIT, so it is already clear on entry.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
  logic        tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
  assign err     = err_q;
`else
  // TIMEOUT only matters when the watchdog is compiled in.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
  assign err = 1'b0;
`endif

  // The CPU is held in its request cycle and while the bus is busy; RESP releases it.
  assign cpu_ready  = (state_q == IDLE);
  assign stall      = (state_q == MEM_WAIT) | (cpu_valid & (state_q == IDLE));
  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_sel    = mem_sel_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Next-state and registered-output logic; rvalid is computed a cycle early so it lands in RESP.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
`ifdef HACK_MEM_TIMEOUT_EN
    err_d       = err_q;
    tmo_cnt_d   = (state_q == MEM_WAIT) ? tmo_cnt_q + 16'd1 : '0;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          case (dec_region)
            RAM, SCREEN: begin
              mem_req_d   = 1'b1;
              mem_we_d    = cpu_we;
              mem_sel_d   = (dec_region == SCREEN);
              mem_addr_d  = dec_offset;
              mem_wdata_d = cpu_wdata;
              state_d     = MEM_WAIT;
            end
            KBD: begin
              // Keyboard writes are silently dropped.
              if (!cpu_we) begin
                rdata_d  = kbd_code;
                rvalid_d = 1'b1;
              end
              state_d = RESP;
            end
            default: begin
              // Unmapped reads return zero; unmapped writes are dropped.
              if (!cpu_we) begin
                rdata_d  = '0;
                rvalid_d = 1'b1;
              end
              state_d = RESP;
            end
          endcase
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
          end
          state_d = RESP;
        end
`ifdef HACK_MEM_TIMEOUT_EN
        else if (tmo_hit) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (!mem_we_q) begin
            rdata_d  = 16'hFFFF;
            rvalid_d = 1'b1;
          end
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight bus request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
`ifdef HACK_MEM_TIMEOUT_EN
      err_q       <= 1'b0;
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
`ifdef HACK_MEM_TIMEOUT_EN
      err_q       <= err_d;
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_hack_mem_port.sv
// Bench for hack_mem_port: directed accesses, bus responder with a memory model, read scoreboard.
// Read completions are checked for data and for the cycle they appear in.
// Bus wait is programmable per access to exercise zero-wait and long-wait handshakes.
module tb_hack_mem_port;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [14:0] cpu_addr;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] kbd_code;
  logic        err;

  hack_mem_port #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .kbd_code   (kbd_code),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: read completions (data + cycle seen) and bus transactions (fields at ack).
  typedef struct {
    logic [15:0] data;
    int          due;
  } rd_exp_t;
  typedef struct {
    logic        sel;
    logic [13:0] addr;
    logic        we;
    logic [15:0] wdata;
  } bus_exp_t;

  rd_exp_t  rd_q[$];
  bus_exp_t bus_q[$];

  logic [15:0] ram_m [0:16383];
  logic [15:0] scr_m [0:8191];

  int  cyc = 0;
  int  bus_delay = 0;
  bit  stray_ack = 0;
  int  bus_starts = 0;
  int  wcnt = 0;
  logic prev_req = 1'b0;
  bus_exp_t bx;
  rd_exp_t  rx;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus responder: acks after bus_delay idle request cycles, so delay 0 acks in the cycle mem_req rises.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !prev_req) bus_starts++;
      prev_req = mem_req;
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (stray_ack) begin
        stray_ack = 0;
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
      end else if (mem_req) begin
        if (wcnt == bus_delay) begin
          mem_ack = 1'b1;
          if (bus_q.size() == 0) begin
            check("bus_unexpected", 1, 0);
          end else begin
            bx = bus_q.pop_front();
            check("bus_sel", mem_sel, bx.sel);
            check("bus_addr", mem_addr, bx.addr);
            check("bus_we", mem_we, bx.we);
            if (bx.we) check("bus_wdata", mem_wdata, bx.wdata);
          end
          if (mem_we) begin
            if (mem_sel) scr_m[mem_addr[12:0]] = mem_wdata;
            else         ram_m[mem_addr]       = mem_wdata;
          end else begin
            mem_rdata = mem_sel ? scr_m[mem_addr[12:0]] : ram_m[mem_addr];
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Completion monitor; a completion is visible in the cycle before the edge counted as its latency.
  initial forever begin
    @(negedge clk);
    if (cpu_rvalid) begin
      if (rd_q.size() == 0) begin
        check("rvalid_unexpected", 1, 0);
      end else begin
        rx = rd_q.pop_front();
        check("rdata", cpu_rdata, rx.data);
        check("rvalid_cycle", cyc, rx.due);
        check("stall_in_resp", stall, 0);
      end
    end
    if (mem_req) check("stall_in_wait", stall, 1);
  end

  function automatic int region_of(input logic [15:0] a);
    if (a <= 16'h3FFF)      return 0;
    else if (a <= 16'h5FFF) return 1;
    else if (a == 16'h6000) return 2;
    else                    return 3;
  endfunction

  // Present one access from a negedge, wait for acceptance, record expectations; returns the accept cycle.
  task automatic issue(input logic [14:0] a, input logic we, input logic [15:0] wd,
                       input bit tmo, output int acc);
    logic [15:0] a16;
    logic [15:0] so;
    logic [15:0] ed;
    int          rg;
    int          lat;
    bus_exp_t    be;
    rd_exp_t     re;
    a16 = {1'b0, a};
    so  = a16 - 16'h4000;
    rg  = region_of(a16);
    cpu_addr  = a;
    cpu_we    = we;
    cpu_wdata = wd;
    cpu_valid = 1'b1;
    #1;
    for (int i = 0; i < 200 && !cpu_ready; i++) @(negedge clk);
    check("accept_ready", cpu_ready, 1);
    if (!cpu_ready) begin
      cpu_valid = 1'b0;
      acc = -1;
      return;
    end
    check("stall_request", stall, 1);
    acc = cyc + 1;
    ed  = 16'h0000;
    lat = 1;
    if (rg <= 1) begin
      lat = tmo ? TB_TIMEOUT + 1 : bus_delay + 2;
      if (tmo) ed = 16'hFFFF;
      else     ed = (rg == 0) ? ram_m[a[13:0]] : scr_m[so[12:0]];
      if (!tmo) begin
        be.sel   = (rg == 1);
        be.addr  = (rg == 0) ? a[13:0] : so[13:0];
        be.we    = we;
        be.wdata = wd;
        bus_q.push_back(be);
      end
    end else if (rg == 2) begin
      ed = kbd_code;
    end
    if (!we) begin
      re.data = ed;
      re.due  = acc + lat - 1;
      rd_q.push_back(re);
    end
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rd_q.size() == 0 && bus_q.size() == 0 && cpu_ready && !mem_req) begin
        done = 1;
        break;
      end
    end
    check("drain", done, 1);
  endtask

  int a1, a2, bs;

  initial begin
    reset     = 1'b1;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    cpu_we    = 1'b0;
    cpu_wdata = '0;
    kbd_code  = 16'h0000;
    for (int i = 0; i < 16384; i++) ram_m[i] = 16'(16'h0100 + i * 3);
    for (int i = 0; i < 8192; i++)  scr_m[i] = 16'(16'hC000 + i);
    ram_m[16] = 16'hBEEF;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 1);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    // 1: reset while a RAM read waits on the bus.
    bus_delay = 1000;
    issue(15'h0005, 1'b0, 16'h0000, 0, a1);
    repeat (2) @(negedge clk);
    check("t1_req_pending", mem_req, 1);
    reset = 1'b1;
    rd_q.delete();
    bus_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("t1_req_dropped", mem_req, 0);
    check("t1_ready", cpu_ready, 1);
    check("t1_rdata", cpu_rdata, 0);
    check("t1_rvalid", cpu_rvalid, 0);
    repeat (4) @(negedge clk);

    // 2: RAM read with three wait cycles.
    bus_delay = 3;
    issue(15'h0010, 1'b0, 16'h0000, 0, a1);
    wait_idle();
    check("t2_rdata", cpu_rdata, 16'hBEEF);

    // 3: screen write, then read it back.
    bs = bus_starts;
    bus_delay = 2;
    issue(15'h4001, 1'b1, 16'h00FF, 0, a1);
    wait_idle();
    check("t3_rdata_kept", cpu_rdata, 16'hBEEF);
    check("t3_screen_word", scr_m[1], 16'h00FF);
    check("t3_bus_starts", bus_starts - bs, 1);
    issue(15'h4001, 1'b0, 16'h0000, 0, a1);
    wait_idle();
    check("t3_readback", cpu_rdata, 16'h00FF);

    // Region edges: last RAM word and last screen word.
    bus_delay = 1;
    issue(15'h3FFF, 1'b0, 16'h0000, 0, a1);
    issue(15'h5FFF, 1'b0, 16'h0000, 0, a2);
    wait_idle();

    // 4: keyboard and unmapped, none of which may touch the bus.
    bs = bus_starts;
    kbd_code = 16'h0083;
    issue(15'h6000, 1'b0, 16'h0000, 0, a1);
    wait_idle();
    check("t4_kbd", cpu_rdata, 16'h0083);
    issue(15'h7000, 1'b0, 16'h0000, 0, a1);
    wait_idle();
    check("t4_none", cpu_rdata, 16'h0000);
    issue(15'h6000, 1'b1, 16'h5555, 0, a1);
    issue(15'h7FFF, 1'b1, 16'hAAAA, 0, a2);
    wait_idle();
    check("t4_write_no_rdata", cpu_rdata, 16'h0000);
    kbd_code = 16'h0041;
    issue(15'h6000, 1'b0, 16'h0000, 0, a1);
    issue(15'h6001, 1'b0, 16'h0000, 0, a2);
    wait_idle();
    check("t4_local_gap", a2 - a1, 2);
    check("t4_no_bus", bus_starts - bs, 0);

    // 5: ack in the request cycle, back-to-back with cpu_valid held; then a stray ack.
    bus_delay = 0;
    issue(15'h0020, 1'b0, 16'h0000, 0, a1);
    issue(15'h0021, 1'b0, 16'h0000, 0, a2);
    wait_idle();
    check("t5_bus_gap", a2 - a1, 3);
    stray_ack = 1;
    repeat (4) @(negedge clk);
    check("t5_stray_rdata", cpu_rdata, ram_m[16'h0021]);
    check("t5_stray_ready", cpu_ready, 1);
    check("t5_stray_req", mem_req, 0);

`ifdef HACK_MEM_TIMEOUT_EN
    // 6: watchdog fires on a read that is never acked.
    bus_delay = 1000;
    issue(15'h0030, 1'b0, 16'h0000, 1, a1);
    wait_idle();
    check("t6_err", err, 1);
    check("t6_rdata", cpu_rdata, 16'hFFFF);
    bus_delay = 0;
    issue(15'h0031, 1'b0, 16'h0000, 0, a1);
    wait_idle();
    check("t6_err_sticky", err, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_err_cleared", err, 0);
`else
    check("err_tied_low", err, 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "global timeout");
  end

endmodule
